vmem_addrgen: RTL
=================

VMEM_ADDRGEN -- requirements
Module: vmem_addrgen

Interface
REQ-001 Parameter WIDTH, default 32, address/data width.
REQ-002 Parameter LOG2NUMREGS, default 3, inc register index width.
REQ-003 Parameter LOG2MVL, default 6, log2 of maximum vector length (MVL = 64).
REQ-004 clk  input  1  sole clock; all state on rising edge.
REQ-005 resetn  input  1  reset, asynchronous, active-low.
REQ-006 start  input  1  request to begin one strided address sequence; sampled only in IDLE.
REQ-007 base  input  WIDTH  starting address; captured with start.
REQ-008 vl  input  LOG2MVL+1  element count; captured with start.
REQ-009 inc_sel  input  LOG2NUMREGS  inc register holding the stride; captured with start.
REQ-010 postinc  input  1  request base write-back at end; captured with start.
REQ-011 flush  input  1  synchronous abort.
REQ-012 inc_reg  output  LOG2NUMREGS  read address to inc register file.
REQ-013 inc_en  output  1  read enable to inc register file.
REQ-014 inc_readdata  input  WIDTH  stride; valid the cycle after inc_en is high.
REQ-015 addr_valid  output  1  addr holds a valid element address.
REQ-016 addr_ready  input  1  consumer accepts addr this cycle.
REQ-017 addr  output  WIDTH  element address.
REQ-018 addr_idx  output  LOG2MVL  element index of addr.
REQ-019 addr_last  output  1  addr is the final element.
REQ-020 busy  output  1  high in every state except IDLE.
REQ-021 done  output  1  one-cycle completion pulse.
REQ-022 wb_we  output  1  one-cycle base write-back strobe.
REQ-023 wb_base  output  WIDTH  post-incremented base.

Function
REQ-024 States: IDLE, FETCH, CAPT, GEN, FIN; one-hot or encoded.
REQ-025 IDLE: start=1 captures base, vl, inc_sel, postinc -> FETCH; start ignored in all other states.
REQ-026 vl greater than 2^LOG2MVL shall be clamped to 2^LOG2MVL at capture.
REQ-027 FETCH: inc_en=1, inc_reg=captured inc_sel, exactly one cycle -> CAPT.
REQ-028 CAPT: stride register <= inc_readdata; cur <= base; idx <= 0; -> GEN if vl!=0, else -> FIN.
REQ-029 Stride from inc_sel=0 is 0 (register file guarantees); no special handling.
REQ-030 GEN: addr_valid=1, addr=cur, addr_idx=idx, addr_last=(idx==vl-1).
REQ-031 Handshake: transfer when addr_valid&addr_ready; addr/addr_idx/addr_last hold stable while addr_ready=0.
REQ-032 On transfer: cur <= cur+stride (modulo 2^WIDTH, two's complement wrap), idx <= idx+1; if addr_last, -> FIN.
REQ-033 FIN: done=1 for one cycle; wb_we=postinc; wb_base=cur (=base+vl*stride mod 2^WIDTH; =base when vl=0); -> IDLE.
REQ-034 Throughput: one address per cycle while addr_ready=1; start-to-first-addr_valid latency 3 cycles.
REQ-035 flush=1 in any state -> IDLE next cycle; no done, no wb_we; flush has priority over start and transfer.
REQ-036 start and flush both high in IDLE: remain IDLE.
REQ-037 Outputs addr_valid, addr_last, done, wb_we, inc_en shall be 0 outside their defined states.
REQ-038 New start accepted in the cycle immediately after FIN (back-to-back sequences).

Reset
REQ-039 resetn=0 forces state IDLE immediately, regardless of clock.
REQ-040 Reset values: addr=0, addr_idx=0, addr_valid=0, addr_last=0, busy=0, done=0, wb_we=0, wb_base=0, inc_en=0, inc_reg=0, stride=0.
REQ-041 Reset mid-sequence discards all captured state; no done or wb_we after release.

Verification
REQ-042 base=0x1000, vl=4, inc_sel=2 (stride 8), addr_ready=1 -> addrs 0x1000,0x1008,0x1010,0x1018, idx 0..3, last on 0x1018, done next cycle.
REQ-043 Same with postinc=1 -> wb_we pulse with wb_base=0x1020 coincident with done.
REQ-044 vl=0, postinc=1 -> no addr_valid, done and wb_we in cycle 3, wb_base=base.
REQ-045 base=0xFFFFFFF8, stride 8, vl=2, addr_ready toggling 1-0-1 -> addrs 0xFFFFFFF8 then 0x00000000, second held stable through stall.
REQ-046 flush asserted at idx=2 of vl=8 -> IDLE next cycle, no done/wb_we; following start runs normally.
REQ-047 resetn pulled low mid-GEN -> all outputs 0 asynchronously, busy=0 after release.

Source files
------------

// File: rtl/vmem_addrgen.sv
// rtl/vmem_addrgen.sv - strided vector memory address generator
// Fetches a stride from the inc register file, then streams base + i*stride addresses with valid/ready.
module vmem_addrgen #(
    parameter int WIDTH       = 32,
    parameter int LOG2NUMREGS = 3,
    parameter int LOG2MVL     = 6
) (
    input  logic                   clk,
    input  logic                   resetn,
    input  logic                   start,
    input  logic [WIDTH-1:0]       base,
    input  logic [LOG2MVL:0]       vl,
    input  logic [LOG2NUMREGS-1:0] inc_sel,
    input  logic                   postinc,
    input  logic                   flush,
    output logic [LOG2NUMREGS-1:0] inc_reg,
    output logic                   inc_en,
    input  logic [WIDTH-1:0]       inc_readdata,
    output logic                   addr_valid,
    input  logic                   addr_ready,
    output logic [WIDTH-1:0]       addr,
    output logic [LOG2MVL-1:0]     addr_idx,
    output logic                   addr_last,
    output logic                   busy,
    output logic                   done,
    output logic                   wb_we,
    output logic [WIDTH-1:0]       wb_base
);

    typedef enum logic [2:0] {S_IDLE, S_FETCH, S_CAPT, S_GEN, S_FIN} state_t;

    localparam logic [LOG2MVL:0] MVL     = {1'b1, {LOG2MVL{1'b0}}};
    localparam logic [LOG2MVL:0] VL_ONE  = (LOG2MVL+1)'(1);
    localparam logic [LOG2MVL-1:0] IDX_ONE = LOG2MVL'(1);

    state_t                   state_q, state_d;
    logic [WIDTH-1:0]         base_q, base_d;
    logic [LOG2MVL:0]         vl_q, vl_d;
    logic [LOG2NUMREGS-1:0]   inc_sel_q, inc_sel_d;
    logic                     postinc_q, postinc_d;
    logic [WIDTH-1:0]         stride_q, stride_d;
    logic [WIDTH-1:0]         cur_q, cur_d;
    logic [LOG2MVL-1:0]       idx_q, idx_d;
    logic                     is_last;

    assign is_last = ({1'b0, idx_q} == (vl_q - VL_ONE));

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // flush outranks every other transition, including start and transfer
    always_comb begin
        state_d = state_q;
        if (flush) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE:  if (start) state_d = S_FETCH;
                S_FETCH: state_d = S_CAPT;
                S_CAPT:  state_d = (vl_q != '0) ? S_GEN : S_FIN;
                S_GEN:   if (addr_ready && is_last) state_d = S_FIN;
                S_FIN:   state_d = S_IDLE;
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_comb begin
        inc_en     = (state_q == S_FETCH);
        addr_valid = (state_q == S_GEN);
        addr_last  = (state_q == S_GEN) && is_last;
        done       = (state_q == S_FIN) && !flush;
        wb_we      = (state_q == S_FIN) && !flush && postinc_q;
        busy       = (state_q != S_IDLE);
        inc_reg    = inc_sel_q;
        addr       = cur_q;
        addr_idx   = idx_q;
        wb_base    = cur_q;
    end

    always_comb begin
        base_d    = base_q;
        vl_d      = vl_q;
        inc_sel_d = inc_sel_q;
        postinc_d = postinc_q;
        stride_d  = stride_q;
        cur_d     = cur_q;
        idx_d     = idx_q;
        if (!flush) begin
            case (state_q)
                S_IDLE: if (start) begin
                    base_d    = base;
                    vl_d      = (vl > MVL) ? MVL : vl;
                    inc_sel_d = inc_sel;
                    postinc_d = postinc;
                end
                S_CAPT: begin
                    stride_d = inc_readdata;
                    cur_d    = base_q;
                    idx_d    = '0;
                end
                S_GEN: if (addr_ready) begin
                    cur_d = cur_q + stride_q;
                    idx_d = idx_q + IDX_ONE;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            base_q    <= '0;
            vl_q      <= '0;
            inc_sel_q <= '0;
            postinc_q <= 1'b0;
            stride_q  <= '0;
            cur_q     <= '0;
            idx_q     <= '0;
        end else begin
            base_q    <= base_d;
            vl_q      <= vl_d;
            inc_sel_q <= inc_sel_d;
            postinc_q <= postinc_d;
            stride_q  <= stride_d;
            cur_q     <= cur_d;
            idx_q     <= idx_d;
        end
    end

endmodule
